// File: rtl/blit_pkg.sv
// Shared constants and FSM state type for the sprite blitter and other
// placement logic that works on the 64x48 grid of 10x10-pixel cells.
package blit_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CELL     = 10;
    localparam int FB_AW    = 19;
    localparam int X_MAX    = 63;
    localparam int Y_MAX    = 47;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FETCH,
        WRITE,
        DONE
    } blit_state_e;

endpackage

// File: rtl/cell_to_base.sv
// Converts a cell coordinate into the linear framebuffer address of the
// cell's top-left pixel, using shifts and adds only:
// y*6400 = y<<12 + y<<11 + y<<8, x*10 = x<<3 + x<<1.
module cell_to_base
    import blit_pkg::*;
(
    input  logic [5:0]       x_i,
    input  logic [5:0]       y_i,
    output logic [FB_AW-1:0] base_o
);

    logic [FB_AW-1:0] xExt;
    logic [FB_AW-1:0] yExt;

    assign xExt = FB_AW'(x_i);
    assign yExt = FB_AW'(y_i);

    // Largest operand (63*6400 + 630) stays well inside 19 bits, so no wrap.
    assign base_o = (yExt << 12) + (yExt << 11) + (yExt << 8)
                  + (xExt << 3) + (xExt << 1);

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Copies one IMG_W x IMG_H sprite from a synchronous ROM into the linear
// framebuffer at a cell position, skipping transparent pixels and waiting
// on framebuffer back-pressure for every real write.
module sprite_blit_ctrl
    import blit_pkg::*;
#(
    parameter int                 IMG_W       = 10,
    parameter int                 IMG_H       = 10,
    parameter int                 PIX_W       = 8,
    parameter logic [PIX_W-1:0]   TRANSPARENT = 8'hE3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [5:0]                        cell_x,
    input  logic [5:0]                        cell_y,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [$clog2(IMG_W*IMG_H)-1:0]    rom_addr,
    input  logic [PIX_W-1:0]                  rom_data,
    output logic [FB_AW-1:0]                  fb_addr,
    output logic [PIX_W-1:0]                  fb_data,
    output logic                              fb_we,
    input  logic                              fb_ready
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ROM_AW = $clog2(NPIX);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    blit_state_e        state_q;
    logic [5:0]         cellX_q;
    logic [5:0]         cellY_q;
    logic [FB_AW-1:0]   rowBase_q;
    logic [COL_W-1:0]   col_q;
    logic [ROM_AW-1:0]  pix_q;
    logic [FB_AW-1:0]   fbAddr_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [FB_AW-1:0]   cellBase;
    logic               isTransparent;
    logic               advance;
    logic               lastPix;

    cell_to_base u_cell_to_base (
        .x_i    (cellX_q),
        .y_i    (cellY_q),
        .base_o (cellBase)
    );

    // A pixel is finished when it needs no write, or when its write is accepted.
    always_comb begin
        isTransparent = (rom_data == TRANSPARENT);
        advance       = isTransparent || fb_ready;
        lastPix       = (pix_q == ROM_AW'(NPIX - 1));
    end

    // Main sequencer: request validation, base calculation and the row-major pixel walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cellX_q   <= '0;
            cellY_q   <= '0;
            rowBase_q <= '0;
            col_q     <= '0;
            pix_q     <= '0;
            fbAddr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if ((cell_x == '0) || (cell_y == '0) || (cell_y > 6'(Y_MAX))) begin
                            err_q <= 1'b1;
                        end else begin
                            cellX_q <= cell_x;
                            cellY_q <= cell_y;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rowBase_q <= cellBase;
                    col_q     <= '0;
                    pix_q     <= '0;
                    state_q   <= FETCH;
                end
                FETCH: begin
                    fbAddr_q <= rowBase_q + FB_AW'(col_q);
                    state_q  <= WRITE;
                end
                WRITE: begin
                    if (advance) begin
                        if (lastPix) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                            if (col_q == COL_W'(IMG_W - 1)) begin
                                col_q     <= '0;
                                rowBase_q <= rowBase_q + FB_AW'(SCREEN_W);
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // pix_q is held from FETCH through WRITE, so the ROM output stays stable
    // for the whole (possibly stalled) write; fb_data forwards that registered
    // ROM output rather than adding a cycle of delay.
    always_comb begin
        busy     = busy_q;
        done     = done_q;
        err      = err_q;
        rom_addr = pix_q;
        fb_addr  = fbAddr_q;
        fb_we    = (state_q == WRITE) && !isTransparent;
        fb_data  = (state_q == WRITE) ? rom_data : '0;
    end

endmodule
